// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, program memory loaded by the debug
// unit, next-PC selection and the IF/ID pipeline register feeding decode.
module instruction_fetch #(
    parameter int              len       = 32,
    parameter int              MEM_DEPTH = 1024,
    parameter int              ADDR_W    = $clog2(MEM_DEPTH),
    parameter logic [len-1:0]  HALT_WORD = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        in_pc_src,
    input  logic [len-1:0]    in_pc_branch,
    input  logic [len-1:0]    in_pc_jump,
    input  logic [len-1:0]    in_pc_register,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [len-1:0]    prog_data,
    output logic [len-1:0]    out_pc_branch,
    output logic [len-1:0]    out_instruccion,
    output logic              out_valid,
    output logic              out_halt,
    output logic [len-1:0]    out_pc
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]     r_state;
    logic [len-1:0] r_pc;
    logic [len-1:0] r_ifid_instr;
    logic [len-1:0] r_ifid_pcb;
    logic           r_valid;
    logic           r_halt;
    logic [len-1:0] r_mem [MEM_DEPTH];

    logic [len-1:0] w_pc_plus4;
    logic [len-1:0] w_next_pc;
    logic [len-1:0] w_fetch_word;
    logic           w_is_halt;
    // jr targets are forced word-aligned, so the low two bits never matter
    logic           w_unused_reg_lsbs;

    assign w_pc_plus4        = r_pc + len'(4);
    // Word-addressed asynchronous read; upper PC bits drop out so fetch wraps
    assign w_fetch_word      = r_mem[r_pc[ADDR_W+1:2]];
    assign w_is_halt         = (w_fetch_word == HALT_WORD);
    assign w_unused_reg_lsbs = &{1'b0, in_pc_register[1:0]};

    // Next-PC source select driven by downstream branch/jump resolution
    always_comb begin
        w_next_pc = w_pc_plus4;
        case (in_pc_src)
            2'b00:   w_next_pc = w_pc_plus4;
            2'b01:   w_next_pc = in_pc_branch;
            2'b10:   w_next_pc = in_pc_jump;
            2'b11:   w_next_pc = {in_pc_register[len-1:2], 2'b00};
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    // Program load port; only the debug unit writes, and only before run
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && prog_we)
            r_mem[prog_addr] <= prog_data;
    end

    // Stage control FSM, PC and IF/ID register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_LOAD;
            r_pc         <= '0;
            r_ifid_instr <= '0;
            r_ifid_pcb   <= '0;
            r_valid      <= 1'b0;
            r_halt       <= 1'b0;
        end else begin
            case (r_state)
                // The cycle that leaves LOAD already performs the first fetch
                S_LOAD, S_RUN: begin
                    if (enable) begin
                        r_state <= S_RUN;
                        if (flush) begin
                            r_pc         <= w_next_pc;
                            r_ifid_instr <= '0;
                            r_ifid_pcb   <= '0;
                            r_valid      <= 1'b0;
                        end else if (!stall) begin
                            r_pc         <= w_next_pc;
                            r_ifid_instr <= w_fetch_word;
                            r_ifid_pcb   <= w_pc_plus4;
                            r_valid      <= 1'b1;
                            if (w_is_halt) begin
                                r_halt  <= 1'b1;
                                r_state <= S_HALT;
                            end
                        end
                    end
                end
                // Halted: bubble IF/ID; a flush means the halt was speculative
                S_HALT: begin
                    if (enable) begin
                        r_ifid_instr <= '0;
                        r_ifid_pcb   <= '0;
                        r_valid      <= 1'b0;
                        if (flush) begin
                            r_pc    <= w_next_pc;
                            r_halt  <= 1'b0;
                            r_state <= S_RUN;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign out_pc_branch   = r_ifid_pcb;
    assign out_instruccion = r_ifid_instr;
    assign out_valid       = r_valid;
    assign out_halt        = r_halt;
    assign out_pc          = r_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: each scenario pushes the IF/ID it
// expects after the next clock and pops/compares once that clock has passed.
module tb_instruction_fetch;
    localparam int          AW   = 10;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0, stall = 1'b0, flush = 1'b0, prog_we = 1'b0;
    logic [1:0]    in_pc_src = 2'b00;
    logic [31:0]   in_pc_branch = '0, in_pc_jump = '0, in_pc_register = '0;
    logic [31:0]   prog_data = '0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   out_pc_branch, out_instruccion, out_pc;
    logic          out_valid, out_halt;

    instruction_fetch dut (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall), .flush(flush),
        .in_pc_src(in_pc_src), .in_pc_branch(in_pc_branch), .in_pc_jump(in_pc_jump),
        .in_pc_register(in_pc_register), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .out_pc_branch(out_pc_branch),
        .out_instruccion(out_instruccion), .out_valid(out_valid),
        .out_halt(out_halt), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcb;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic v, input logic h);
        exp_t x;
        x = '{instr: i, pcb: p, valid: v, halt: h};
        sb.push_back(x);
    endtask

    task automatic do_reset;
        enable = 1'b0; stall = 1'b0; flush = 1'b0; in_pc_src = 2'b00;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic load_program;
        logic [AW-1:0] a [9];
        logic [31:0]   d [9];
        a = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd8, 10'd16, 10'd1023};
        d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, HALT, 32'h88, 32'h1010, 32'hABCD};
        for (int k = 0; k < 9; k++) begin
            prog_we = 1'b1; prog_addr = a[k]; prog_data = d[k];
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic test_reset;
        tick(); tick();
        push(32'h0, 32'h0, 1'b0, 1'b0);
        e = sb.pop_front(); n_total++;
        if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
            $display("FAIL reset_ifid got %h expected %h", {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
        else n_pass++;
        n_total++;
        if (out_pc !== 32'h0) $display("FAIL reset_pc got %h expected %h", out_pc, 32'h0);
        else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch;
        logic [31:0] w [4];
        w = '{32'h11, 32'h22, 32'h33, 32'h44};
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(w[k], 32'(4 * (k + 1)), 1'b1, 1'b0);
            tick();
            e = sb.pop_front(); n_total++;
            if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
                $display("FAIL fetch%0d got %h expected %h", k, {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
            else n_pass++;
        end
        n_total++;
        if (out_pc !== 32'h10) $display("FAIL fetch_pc got %h expected %h", out_pc, 32'h10);
        else n_pass++;
    endtask

    task automatic test_stall;
        do_reset();
        enable = 1'b1;
        tick(); tick();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(32'h22, 32'h8, 1'b1, 1'b0);
            tick();
            e = sb.pop_front(); n_total++;
            if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
                $display("FAIL stall_ifid%0d got %h expected %h", k, {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
            else n_pass++;
            n_total++;
            if (out_pc !== 32'h8) $display("FAIL stall_pc%0d got %h expected %h", k, out_pc, 32'h8);
            else n_pass++;
        end
        stall = 1'b0;
        push(32'h33, 32'hC, 1'b1, 1'b0);
        tick();
        e = sb.pop_front(); n_total++;
        if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
            $display("FAIL stall_release got %h expected %h", {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
        else n_pass++;
    endtask

    task automatic test_flush_branch;
        in_pc_src = 2'b01; in_pc_branch = 32'h20; flush = 1'b1;
        push(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); n_total++;
        if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
            $display("FAIL flush_nop got %h expected %h", {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
        else n_pass++;
        flush = 1'b0; in_pc_src = 2'b00;
        push(32'h88, 32'h24, 1'b1, 1'b0);
        tick();
        e = sb.pop_front(); n_total++;
        if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
            $display("FAIL branch_target got %h expected %h", {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
        else n_pass++;
    endtask

    task automatic test_stall_flush_jump;
        stall = 1'b1; flush = 1'b1; in_pc_src = 2'b10; in_pc_jump = 32'h40;
        push(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        e = sb.pop_front(); n_total++;
        if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
            $display("FAIL stallflush_nop got %h expected %h", {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
        else n_pass++;
        n_total++;
        if (out_pc !== 32'h40) $display("FAIL jump_pc got %h expected %h", out_pc, 32'h40);
        else n_pass++;
        stall = 1'b0; flush = 1'b0; in_pc_src = 2'b11; in_pc_register = 32'h13;
        push(32'h1010, 32'h44, 1'b1, 1'b0);
        tick();
        e = sb.pop_front(); n_total++;
        if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
            $display("FAIL jump_fetch got %h expected %h", {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
        else n_pass++;
        n_total++;
        if (out_pc !== 32'h10) $display("FAIL jr_pc got %h expected %h", out_pc, 32'h10);
        else n_pass++;
        in_pc_src = 2'b00;
    endtask

    task automatic test_halt;
        push(32'h55, 32'h14, 1'b1, 1'b0);
        push(HALT, 32'h18, 1'b1, 1'b1);
        push(32'h0, 32'h0, 1'b0, 1'b1);
        push(32'h0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            e = sb.pop_front(); n_total++;
            if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
                $display("FAIL halt_seq%0d got %h expected %h", k, {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
            else n_pass++;
        end
        n_total++;
        if (out_pc !== 32'h18) $display("FAIL halt_pc got %h expected %h", out_pc, 32'h18);
        else n_pass++;
        // asynchronous reset: outputs clear without waiting for a clock
        reset = 1'b0; enable = 1'b0;
        #1;
        push(32'h0, 32'h0, 1'b0, 1'b0);
        e = sb.pop_front(); n_total++;
        if ({out_instruccion, out_pc_branch, out_valid, out_halt, out_pc} !== {e, 32'h0})
            $display("FAIL async_reset got %h expected %h", {out_instruccion, out_pc_branch, out_valid, out_halt, out_pc}, {e, 32'h0});
        else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        enable = 1'b1;
        push(32'h11, 32'h4, 1'b1, 1'b0);
        tick();
        e = sb.pop_front(); n_total++;
        if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
            $display("FAIL mem_retained got %h expected %h", {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
        else n_pass++;
    endtask

    task automatic test_halt_flush;
        flush = 1'b1; in_pc_src = 2'b10; in_pc_jump = 32'h14;
        tick();
        flush = 1'b0; in_pc_src = 2'b00;
        tick();
        flush = 1'b1; in_pc_src = 2'b10; in_pc_jump = 32'h0;
        push(32'h0, 32'h0, 1'b0, 1'b0);
        push(32'h11, 32'h4, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            flush = 1'b0; in_pc_src = 2'b00;
            e = sb.pop_front(); n_total++;
            if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
                $display("FAIL halt_exit%0d got %h expected %h", k, {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
            else n_pass++;
        end
    endtask

    task automatic test_enable_hold;
        enable = 1'b0; stall = 1'b1; flush = 1'b1; in_pc_src = 2'b10; in_pc_jump = 32'h80;
        push(32'h11, 32'h4, 1'b1, 1'b0);
        tick(); tick();
        e = sb.pop_front(); n_total++;
        if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
            $display("FAIL enable_hold got %h expected %h", {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
        else n_pass++;
        n_total++;
        if (out_pc !== 32'h4) $display("FAIL enable_hold_pc got %h expected %h", out_pc, 32'h4);
        else n_pass++;
        enable = 1'b1; stall = 1'b0; flush = 1'b0; in_pc_src = 2'b00;
    endtask

    task automatic test_wrap;
        logic [31:0] jmp [4];
        logic [1:0]  src [4];
        jmp = '{32'h1000, 32'h0, 32'hFFFFFFFC, 32'h0};
        src = '{2'b10, 2'b00, 2'b10, 2'b00};
        push(32'h22, 32'h8, 1'b1, 1'b0);
        push(32'h11, 32'h1004, 1'b1, 1'b0);
        push(32'h22, 32'h1008, 1'b1, 1'b0);
        push(32'hABCD, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            in_pc_src = src[k]; in_pc_jump = jmp[k];
            tick();
            e = sb.pop_front(); n_total++;
            if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
                $display("FAIL wrap%0d got %h expected %h", k, {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
            else n_pass++;
        end
        in_pc_src = 2'b00;
        n_total++;
        if (out_pc !== 32'h0) $display("FAIL wrap_pc got %h expected %h", out_pc, 32'h0);
        else n_pass++;
    endtask

    task automatic test_prog_ignored;
        prog_we = 1'b1; prog_addr = '0; prog_data = 32'hDEAD;
        tick(); tick();
        prog_we = 1'b0;
        do_reset();
        enable = 1'b1;
        push(32'h11, 32'h4, 1'b1, 1'b0);
        tick();
        e = sb.pop_front(); n_total++;
        if ({out_instruccion, out_pc_branch, out_valid, out_halt} !== e)
            $display("FAIL prog_ignored got %h expected %h", {out_instruccion, out_pc_branch, out_valid, out_halt}, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        load_program();
        test_fetch();
        test_stall();
        test_flush_branch();
        test_stall_flush_jump();
        test_halt();
        test_halt_flush();
        test_enable_hold();
        test_wrap();
        test_prog_ignored();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
